// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB TX packet sequencer.
// Contents: sequencer state enum, registered control-output bundle, shifter
// source-select codes, SYNC byte, and the data-PID classifier.
package usb_tx_pkg;

  localparam int unsigned BIT_CNT_W = 3;

  // SYNC pattern as loaded into an LSB-first shifter
  localparam logic [7:0] SYNC_BYTE = 8'h80;

  // Shifter source select codes
  localparam logic [1:0] SEL_HDR    = 2'b00;
  localparam logic [1:0] SEL_FIFO   = 2'b01;
  localparam logic [1:0] SEL_CRC_LO = 2'b10;
  localparam logic [1:0] SEL_CRC_HI = 2'b11;

  // Bit index of the eighth bit of a byte (bits counted 0..7)
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(7);

  // EOP: periods 0..1 drive SE0, period 2 is the trailing J
  localparam logic [BIT_CNT_W-1:0] EOP_SE0_PERIODS = BIT_CNT_W'(2);
  localparam logic [BIT_CNT_W-1:0] EOP_LAST_PERIOD = BIT_CNT_W'(2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_CRC_LO,
    ST_CRC_HI,
    ST_EOP,
    ST_DONE
  } tx_state_e;

  // All sequencer outputs, registered together
  typedef struct packed {
    logic       shift_enable;
    logic       load_enable;
    logic [1:0] tx_sel;
    logic [7:0] tx_hdr_byte;
    logic       fifo_pop;
    logic       crc_clear;
    logic       crc_enable;
    logic       eop;
    logic       tx_busy;
    logic       tx_done;
  } tx_ctrl_t;

  // DATA0/DATA1/DATA2/MDATA all have PID[1:0] = 2'b11
  function automatic logic is_data_pid(input logic [3:0] pid);
    return (pid & 4'b0011) == 4'b0011;
  endfunction

endpackage

// File: rtl/usb_tx_sequencer_bit_timer.sv
// Bit-period timer for the USB TX sequencer.
// Counts 0..CLKS_PER_BIT-1 and wraps; bit_strobe_c is high on the last clock
// of every bit period.
// Ports:
//   clk          in  system clock
//   n_rst        in  synchronous active-low reset
//   clear        in  hold the count at 0 (next cycle starts a fresh period)
//   bit_strobe_c out last clock of the current bit period (combinational)
module tx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  output logic bit_strobe_c
);

  localparam int unsigned TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);

  logic [TMR_W-1:0] timer_q;
  logic [TMR_W-1:0] timer_d;

  // Next count: clear wins, otherwise wrap at the end of the period
  always_comb begin
    timer_d = timer_q + TMR_W'(1);
    if (clear || (timer_q == TMR_LAST)) begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign bit_strobe_c = (timer_q == TMR_LAST);

endmodule

// File: rtl/usb_tx_sequencer.sv
// Packet-level controller for the USB TX byte shifter and NRZI encoder.
// Sequences SYNC, PID, payload, CRC16 and EOP; issues per-bit shift strobes,
// byte load pulses with source select, FIFO pops and CRC16 control, and
// stalls on encoder bit-stuff periods.
// Ports:
//   clk, n_rst      clock, synchronous active-low reset
//   tx_start        1-cycle packet request (accepted only in IDLE)
//   tx_pid          PID nibble, latched with tx_start
//   tx_byte_count   payload length, latched with tx_start (saturates to MAX_BYTES)
//   stuff_hold      encoder is sending a stuffed bit this period
//   shift_enable    shift strobe, one per transmitted bit 1..7 of a byte
//   load_enable     byte load pulse (replaces the shift of bit 8)
//   tx_sel          load source: 00 hdr, 01 fifo, 10 crc lo, 11 crc hi
//   tx_hdr_byte     SYNC/PID byte for the hdr source
//   fifo_pop        advance the show-ahead payload FIFO
//   crc_clear       seed the CRC16
//   crc_enable      CRC16 consumes the current serial bit
//   eop             drive SE0
//   tx_busy         packet in progress
//   tx_done         1-cycle end-of-packet pulse
// All outputs are registered; every pulse appears on the first clock after
// the bit-period boundary that caused it.
module usb_tx_sequencer
  import usb_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned MAX_BYTES    = 64,
  parameter int unsigned CNT_W        = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             tx_start,
  input  logic [3:0]       tx_pid,
  input  logic [CNT_W-1:0] tx_byte_count,
  input  logic             stuff_hold,
  output logic             shift_enable,
  output logic             load_enable,
  output logic [1:0]       tx_sel,
  output logic [7:0]       tx_hdr_byte,
  output logic             fifo_pop,
  output logic             crc_clear,
  output logic             crc_enable,
  output logic             eop,
  output logic             tx_busy,
  output logic             tx_done
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

  tx_state_e              state_q,    state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;
  logic [CNT_W-1:0]       byte_cnt_q, byte_cnt_d;
  logic [3:0]             pid_q,      pid_d;
  tx_ctrl_t               ctrl_q,     ctrl_d;

  logic                   bit_strobe_c;
  logic                   timer_clr_c;
  logic                   in_byte_c;
  logic                   period_end_c;
  logic                   byte_end_c;
  logic [CNT_W-1:0]       sat_count_c;

  // Timer idles at 0 so the first period starts on the cycle after accept
  assign timer_clr_c = (state_q == ST_IDLE) || (state_q == ST_DONE);

  tx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (timer_clr_c),
    .bit_strobe_c (bit_strobe_c)
  );

  assign sat_count_c = (tx_byte_count > MAX_CNT) ? MAX_CNT : tx_byte_count;

  // A byte is on the wire; stuffed periods freeze the bit count
  assign in_byte_c    = (state_q == ST_SYNC)   || (state_q == ST_PID)    ||
                        (state_q == ST_DATA)   || (state_q == ST_CRC_LO) ||
                        (state_q == ST_CRC_HI);
  assign period_end_c = in_byte_c && bit_strobe_c && !stuff_hold;
  assign byte_end_c   = period_end_c && (bit_cnt_q == LAST_BIT);

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    pid_d      = pid_q;
    ctrl_d     = '0;
    // Select and header byte hold so the shifter mux stays stable
    ctrl_d.tx_sel      = ctrl_q.tx_sel;
    ctrl_d.tx_hdr_byte = ctrl_q.tx_hdr_byte;

    // Bits 1..7 shift; bit 8 is replaced by the next load (or nothing)
    if (period_end_c) begin
      ctrl_d.crc_enable = (state_q == ST_DATA);
      if (byte_end_c) begin
        bit_cnt_d = '0;
      end else begin
        ctrl_d.shift_enable = 1'b1;
        bit_cnt_d           = bit_cnt_q + BIT_CNT_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          state_d            = ST_SYNC;
          bit_cnt_d          = '0;
          byte_cnt_d         = sat_count_c;
          pid_d              = tx_pid;
          ctrl_d.load_enable = 1'b1;
          ctrl_d.tx_sel      = SEL_HDR;
          ctrl_d.tx_hdr_byte = SYNC_BYTE;
          ctrl_d.crc_clear   = 1'b1;
        end
      end
      ST_SYNC: begin
        if (byte_end_c) begin
          state_d            = ST_PID;
          ctrl_d.load_enable = 1'b1;
          ctrl_d.tx_sel      = SEL_HDR;
          ctrl_d.tx_hdr_byte = {~pid_q, pid_q};
        end
      end
      ST_PID, ST_DATA: begin
        if (byte_end_c) begin
          if (byte_cnt_q != '0) begin
            state_d            = ST_DATA;
            byte_cnt_d         = byte_cnt_q - CNT_W'(1);
            ctrl_d.load_enable = 1'b1;
            ctrl_d.tx_sel      = SEL_FIFO;
            ctrl_d.fifo_pop    = 1'b1;
          end else if ((state_q == ST_DATA) || is_data_pid(pid_q)) begin
            // Zero-length data packets still carry a CRC
            state_d            = ST_CRC_LO;
            ctrl_d.load_enable = 1'b1;
            ctrl_d.tx_sel      = SEL_CRC_LO;
          end else begin
            state_d = ST_EOP;
          end
        end
      end
      ST_CRC_LO: begin
        if (byte_end_c) begin
          state_d            = ST_CRC_HI;
          ctrl_d.load_enable = 1'b1;
          ctrl_d.tx_sel      = SEL_CRC_HI;
        end
      end
      ST_CRC_HI: begin
        if (byte_end_c) begin
          state_d = ST_EOP;
        end
      end
      ST_EOP: begin
        // Bit counter reused as EOP period counter; stuffing does not apply
        if (bit_strobe_c) begin
          if (bit_cnt_q == EOP_LAST_PERIOD) begin
            state_d   = ST_DONE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ctrl_d.eop     = (state_d == ST_EOP) && (bit_cnt_d < EOP_SE0_PERIODS);
    ctrl_d.tx_busy = (state_d != ST_IDLE) && (state_d != ST_DONE);
    ctrl_d.tx_done = (state_d == ST_DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      pid_q      <= '0;
      ctrl_q     <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      pid_q      <= pid_d;
      ctrl_q     <= ctrl_d;
    end
  end

  assign shift_enable = ctrl_q.shift_enable;
  assign load_enable  = ctrl_q.load_enable;
  assign tx_sel       = ctrl_q.tx_sel;
  assign tx_hdr_byte  = ctrl_q.tx_hdr_byte;
  assign fifo_pop     = ctrl_q.fifo_pop;
  assign crc_clear    = ctrl_q.crc_clear;
  assign crc_enable   = ctrl_q.crc_enable;
  assign eop          = ctrl_q.eop;
  assign tx_busy      = ctrl_q.tx_busy;
  assign tx_done      = ctrl_q.tx_done;

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Self-checking bench for usb_tx_sequencer: directed and randomized packets
// compared cycle by cycle against a byte/bit-period reference model.
module tb_usb_tx_sequencer;

  localparam int CPB  = 8;
  localparam int MAXC = 8192;
  localparam int MAXP = 1024;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       tx_start;
  logic [3:0] tx_pid;
  logic [6:0] tx_byte_count;
  logic       stuff_hold;
  logic       shift_enable, load_enable, fifo_pop, crc_clear, crc_enable;
  logic       eop, tx_busy, tx_done;
  logic [1:0] tx_sel;
  logic [7:0] tx_hdr_byte;

  always #5 clk = ~clk;

  usb_tx_sequencer dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .tx_start      (tx_start),
    .tx_pid        (tx_pid),
    .tx_byte_count (tx_byte_count),
    .stuff_hold    (stuff_hold),
    .shift_enable  (shift_enable),
    .load_enable   (load_enable),
    .tx_sel        (tx_sel),
    .tx_hdr_byte   (tx_hdr_byte),
    .fifo_pop      (fifo_pop),
    .crc_clear     (crc_clear),
    .crc_enable    (crc_enable),
    .eop           (eop),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done)
  );

  int n_vec = 0;
  int n_bad = 0;

  bit         stuff_map [MAXP];
  bit         e_load [MAXC], e_shift [MAXC], e_crc [MAXC], e_pop [MAXC];
  bit         e_eop [MAXC], e_busy [MAXC], e_done [MAXC], e_clr [MAXC];
  logic [1:0] e_sel [MAXC];
  logic [7:0] e_hdr [MAXC];
  int         done_cyc;
  int         n_bytes;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected per-cycle activity; cycle 0 is the tx_start cycle, period p
  // spans cycles 8(p-1)+1..8p and its boundary effect shows at cycle 8p+1.
  task automatic build_model(input logic [3:0] pid, input int cnt);
    logic [1:0] sel_q[$];
    logic [7:0] hdr_q[$];
    int n, p, t, i;
    for (int c = 0; c < MAXC; c++) begin
      e_load[c] = 0; e_shift[c] = 0; e_crc[c] = 0; e_pop[c] = 0;
      e_eop[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_clr[c] = 0;
      e_sel[c] = 2'b00; e_hdr[c] = 8'h00;
    end
    n = (cnt > 64) ? 64 : cnt;
    sel_q.push_back(2'b00); hdr_q.push_back(8'h80);
    sel_q.push_back(2'b00); hdr_q.push_back({~pid, pid});
    for (int k = 0; k < n; k++) begin
      sel_q.push_back(2'b01); hdr_q.push_back(8'h00);
    end
    if (n > 0 || pid[1:0] == 2'b11) begin
      sel_q.push_back(2'b10); hdr_q.push_back(8'h00);
      sel_q.push_back(2'b11); hdr_q.push_back(8'h00);
    end
    n_bytes = sel_q.size();
    e_load[1] = 1; e_sel[1] = 2'b00; e_hdr[1] = 8'h80; e_clr[1] = 1;
    p = 1;
    for (int b = 0; b < n_bytes; b++) begin
      i = 1;
      while (i <= 8) begin
        t = 8 * p + 1;
        if (!stuff_map[p]) begin
          if (sel_q[b] == 2'b01) e_crc[t] = 1;
          if (i < 8) e_shift[t] = 1;
          else if (b + 1 < n_bytes) begin
            e_load[t] = 1;
            e_sel[t]  = sel_q[b+1];
            e_hdr[t]  = hdr_q[b+1];
            e_pop[t]  = (sel_q[b+1] == 2'b01);
          end
          i++;
        end
        p++;
      end
    end
    for (int c = 8 * (p - 1) + 1; c <= 8 * (p + 1); c++) e_eop[c] = 1;
    done_cyc = 8 * (p + 2) + 1;
    for (int c = 1; c < done_cyc; c++) e_busy[c] = 1;
    e_done[done_cyc] = 1;
  endtask

  task automatic run_packet(input string name, input logic [3:0] pid, input logic [6:0] cnt,
                            input int poke, input int abort_at, input int exp_pops,
                            input int exp_crcs, input int exp_done);
    int pops, crcs, shifts, tdone, c, last;
    logic [7:0] obs, exp;
    bit stop;
    pops = 0; crcs = 0; shifts = 0; tdone = -1; stop = 0;
    @(posedge clk); #1;
    check({name, " idle"}, {24'd0, load_enable, shift_enable, tx_busy, tx_done, eop}, 32'd0);
    tx_start = 1'b1; tx_pid = pid; tx_byte_count = cnt; stuff_hold = 1'b0;
    last = done_cyc + 1;
    c = 1;
    while (c <= last && !stop) begin
      @(posedge clk); #1;
      if (abort_at != 0 && c == abort_at + 1) begin
        check($sformatf("%s c%0d reset", name, c),
              {14'd0, load_enable, shift_enable, crc_enable, fifo_pop, eop, tx_busy,
               tx_done, crc_clear, tx_sel, tx_hdr_byte}, 32'd0);
        n_rst = 1'b1;
        stop  = 1;
      end else begin
        obs = {load_enable, shift_enable, crc_enable, fifo_pop, eop, tx_busy, tx_done, crc_clear};
        exp = {e_load[c], e_shift[c], e_crc[c], e_pop[c], e_eop[c], e_busy[c], e_done[c], e_clr[c]};
        check($sformatf("%s c%0d ctl", name, c), {24'd0, obs}, {24'd0, exp});
        if (e_load[c]) begin
          check($sformatf("%s c%0d sel", name, c), {30'd0, tx_sel}, {30'd0, e_sel[c]});
          if (e_sel[c] == 2'b00)
            check($sformatf("%s c%0d hdr", name, c), {24'd0, tx_hdr_byte}, {24'd0, e_hdr[c]});
        end
        pops   += int'(fifo_pop);
        crcs   += int'(crc_enable);
        shifts += int'(shift_enable);
        if (tx_done && tdone < 0) tdone = c;
        // inputs for this cycle: stuffing per period, busy pokes, noisy pid/count
        tx_start      = (c == poke);
        tx_pid        = 4'($urandom);
        tx_byte_count = 7'($urandom);
        stuff_hold    = stuff_map[((c - 1) / CPB + 1) % MAXP];
        if (abort_at != 0 && c == abort_at) n_rst = 1'b0;
      end
      c++;
    end
    tx_start = 1'b0; stuff_hold = 1'b0;
    if (abort_at == 0) begin
      check({name, " pops"},   pops,   exp_pops);
      check({name, " crcs"},   crcs,   exp_crcs);
      check({name, " shifts"}, shifts, 7 * n_bytes);
      check({name, " done"},   tdone,  exp_done);
    end
  endtask

  task automatic clear_stuff();
    for (int k = 0; k < MAXP; k++) stuff_map[k] = 0;
  endtask

  initial begin
    int n, ns, pk;
    logic [3:0] rp;
    logic [6:0] rc;
    n_rst = 1'b0; tx_start = 1'b0; tx_pid = 4'h0; tx_byte_count = 7'd0; stuff_hold = 1'b0;
    clear_stuff();
    repeat (3) @(posedge clk);
    #1;
    check("reset", {14'd0, load_enable, shift_enable, crc_enable, fifo_pop, eop, tx_busy,
                    tx_done, crc_clear, tx_sel, tx_hdr_byte}, 32'd0);
    n_rst = 1'b1;

    // ACK handshake: 19 bit periods from first load
    build_model(4'h2, 0);
    run_packet("ack", 4'h2, 7'd0, 0, 0, 0, 0, 1 + 19 * CPB);

    // DATA0, 3 bytes, start pulsed while busy
    build_model(4'h3, 3);
    run_packet("data0", 4'h3, 7'd3, 300, 0, 3, 24, 1 + 59 * CPB);

    // DATA1 zero-length: CRC bytes follow PID directly
    build_model(4'hB, 0);
    run_packet("data1_zlp", 4'hB, 7'd0, 0, 0, 0, 0, 1 + 35 * CPB);

    // Stuffed period in the middle of data byte 2 adds one period
    stuff_map[28] = 1;
    build_model(4'h3, 3);
    run_packet("stuff", 4'h3, 7'd3, 50, 0, 3, 24, 1 + 60 * CPB);
    clear_stuff();

    // Reset mid-DATA, then a clean restart
    build_model(4'h3, 5);
    run_packet("abort", 4'h3, 7'd5, 0, 200, 0, 0, 0);
    build_model(4'hB, 2);
    run_packet("restart", 4'hB, 7'd2, 0, 0, 2, 16, 1 + 51 * CPB);

    // Oversized count saturates at 64
    build_model(4'h3, 100);
    run_packet("sat", 4'h3, 7'd100, 1000, 0, 64, 512, 1 + (8 * 68 + 3) * CPB);

    // Randomized packets with random stuffing and busy pokes
    for (int r = 0; r < 12; r++) begin
      rp = 4'($urandom);
      rc = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'($urandom_range(0, 12));
      n  = (rc > 64) ? 64 : int'(rc);
      clear_stuff();
      ns = $urandom_range(0, 3);
      for (int k = 0; k < ns; k++) stuff_map[$urandom_range(1, 8 * (4 + n))] = 1;
      build_model(rp, int'(rc));
      pk = $urandom_range(2, done_cyc - 1);
      run_packet($sformatf("rnd%0d", r), rp, rc, pk, 0, n, 8 * n, done_cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
